// File: rtl/sysid_pkg.sv
// Shared definitions for the boot-time system-ID checker and the sysid generator script.
package sysid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_DONE  = 2'd3
    } sysid_state_e;

    localparam logic [31:0] SYSID_ID_DEFAULT        = 32'd11;
    localparam logic [31:0] SYSID_TIMESTAMP_DEFAULT = 32'd1447854940;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Stall counter must hold TIMEOUT_CYCLES itself; never narrower than one bit.
    function automatic int stall_cnt_width(input int unsigned limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words after reset
// and reports whether the loaded FPGA image matches the build-time expectation.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start (or the one-shot autostart after reset)
// ST_RD_ID | read of address 0 outstanding, capturing into id_value
// ST_RD_TS | read of address 1 outstanding, capturing into ts_value
// ST_DONE  | result published (pass/timeout), waiting for a re-run request
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_ID_DEFAULT,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_TIMESTAMP_DEFAULT,
    parameter bit          CHECK_TIMESTAMP    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout
);

    localparam int               CNT_W       = stall_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    sysid_state_e     state, state_next;
    logic [CNT_W-1:0] stall_cnt, stall_cnt_next;
    logic             autostart;
    logic             address_next, read_next, busy_next;
    logic             done_next, pass_next, timeout_next;
    logic [31:0]      id_next, ts_next;
    logic             expired;

    always_comb begin
        state_next     = state;
        stall_cnt_next = stall_cnt;
        address_next   = address;
        read_next      = read;
        busy_next      = busy;
        done_next      = done;
        pass_next      = pass;
        timeout_next   = timeout;
        id_next        = id_value;
        ts_next        = ts_value;
        expired        = TIMEOUT_EN && waitrequest && (stall_cnt == TIMEOUT_CNT);

        unique case (state)
            // autostart is only ever set while still in IDLE, so sharing the launch is safe
            ST_IDLE, ST_DONE: begin
                if (start || autostart) begin
                    state_next     = ST_RD_ID;
                    stall_cnt_next = '0;
                    address_next   = ADDR_ID;
                    read_next      = 1'b1;
                    busy_next      = 1'b1;
                    done_next      = 1'b0;
                    pass_next      = 1'b0;
                    timeout_next   = 1'b0;
                end
            end

            ST_RD_ID: begin
                if (!waitrequest) begin
                    id_next        = readdata;
                    state_next     = ST_RD_TS;
                    address_next   = ADDR_TS;
                    stall_cnt_next = '0;
                end else if (expired) begin
                    state_next     = ST_DONE;
                    stall_cnt_next = '0;
                    read_next      = 1'b0;
                    busy_next      = 1'b0;
                    done_next      = 1'b1;
                    pass_next      = 1'b0;
                    timeout_next   = 1'b1;
                end else begin
                    stall_cnt_next = stall_cnt + 1'b1;
                end
            end

            ST_RD_TS: begin
                if (!waitrequest) begin
                    ts_next        = readdata;
                    state_next     = ST_DONE;
                    stall_cnt_next = '0;
                    read_next      = 1'b0;
                    busy_next      = 1'b0;
                    done_next      = 1'b1;
                    // compare against the word on the bus; ts_value still holds the old one
                    pass_next      = (id_value == EXPECTED_ID) &&
                                     (!CHECK_TIMESTAMP || (readdata == EXPECTED_TIMESTAMP));
                end else if (expired) begin
                    state_next     = ST_DONE;
                    stall_cnt_next = '0;
                    read_next      = 1'b0;
                    busy_next      = 1'b0;
                    done_next      = 1'b1;
                    pass_next      = 1'b0;
                    timeout_next   = 1'b1;
                end else begin
                    stall_cnt_next = stall_cnt + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            stall_cnt <= '0;
            autostart <= AUTO_START;
            address   <= ADDR_ID;
            read      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            state     <= state_next;
            stall_cnt <= stall_cnt_next;
            autostart <= 1'b0;
            address   <= address_next;
            read      <= read_next;
            busy      <= busy_next;
            done      <= done_next;
            pass      <= pass_next;
            timeout   <= timeout_next;
            id_value  <= id_next;
            ts_value  <= ts_next;
        end
    end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Boot-time consumer of the system-ID slave. The block is an Avalon-MM read master that sits directly on the sysid control slave. After reset it reads the ID word (address 0) and the timestamp word (address 1), compares both against build-time expected values, and publishes captured values plus pass/fail/timeout status. The hardware bring-up logic uses these to gate the soft-processor's release from reset on a matching FPGA image.

## Interface
Parameters:
- EXPECTED_ID, 32'd11: required value at address 0.
- EXPECTED_TIMESTAMP, 32'd1447854940: required value at address 1.
- CHECK_TIMESTAMP, 1: when 0, the timestamp is still read and captured but ignored for `pass`.
- TIMEOUT_CYCLES, 255: maximum cycles a single read may stall on `waitrequest`. 0 disables the timeout.
- AUTO_START, 1: when 1, a check launches automatically after reset.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: single-cycle request to run or re-run a check.
- address, out, 1: Avalon address (0 = ID, 1 = timestamp).
- read, out, 1: Avalon read strobe.
- readdata, in, 32: Avalon read data. Valid in any cycle where `read` is high and `waitrequest` is low.
- waitrequest, in, 1: Avalon stall. Tie to 0 for a zero-wait slave.
- id_value, out, 32: captured ID word.
- ts_value, out, 32: captured timestamp word.
- busy, out, 1: a check is in progress.
- done, out, 1: the check has completed. Held until the next check starts.
- pass, out, 1: result is valid only while `done` is high.
- timeout, out, 1: the check aborted on a stalled read.

## Operation
States: IDLE, RD_ID, RD_TS, DONE.

- **Reset.**
  - State goes to IDLE.
  - `read`, `address`, `busy`, `done`, `pass` and `timeout` are all 0.
  - `id_value` and `ts_value` are 0.
  - The stall counter is 0.
  - A one-cycle `autostart` flag is set to AUTO_START.
- **IDLE → RD_ID.** Taken on `start`, or on `autostart` in the first cycle after reset. This transition:
  - clears `done`, `pass` and `timeout`;
  - sets `busy`;
  - sets `read` to 1 and `address` to 0.
- **RD_ID.**
  - `read` is held with `address` 0 until a cycle where `waitrequest` is 0.
  - In that cycle, `readdata` is captured into `id_value`.
  - Next state is RD_TS, with `address` set to 1 and `read` kept at 1. Reads are back-to-back with no idle cycle between them.
- **RD_TS.**
  - Same handshake as RD_ID, capturing into `ts_value`.
  - Next state is DONE, with `read` set to 0.
- **DONE.**
  - `done` is 1 and `busy` is 0.
  - `pass` = (`id_value` == EXPECTED_ID) && (!CHECK_TIMESTAMP || `ts_value` == EXPECTED_TIMESTAMP).
  - The compare is registered on the same edge that enters DONE, using the value being captured (not the stale register).
  - `start` re-enters RD_ID with the same clearing as IDLE → RD_ID.
- **Stall counter.**
  - Width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
  - Increments in each RD cycle where `waitrequest` is 1.
  - Clears on every accepted read and on every state entry.
  - If TIMEOUT_CYCLES ≠ 0 and the counter equals TIMEOUT_CYCLES while `waitrequest` is still 1, the block:
    - drops `read`;
    - goes to DONE with `timeout`=1 and `pass`=0;
    - does not update the captured value for that read.
- **Boundary rules.**
  - `start` is ignored while `busy`.
  - `start` coincident with reset is ignored, since reset has priority.
  - Reset mid-read drops `read` on the next edge. No partial results are kept.
  - `address` changes only on accepted-read edges or state entry, never while a read is stalled.

## Timing
- With `waitrequest` tied to 0 and AUTO_START=1, reset deasserts after edge 0. Then:

  | Cycle | State / outputs |
  |---|---|
  | 1 | IDLE |
  | 2 | RD_ID (`read`=1, `address`=0) |
  | 3 | RD_TS (`address`=1) |
  | 4 | DONE (`done`=1) |

- Total latency is 3 cycles from the start decision to `done`.
- Each stall cycle adds 1 cycle to that latency.
- A timeout fires after TIMEOUT_CYCLES stalled cycles in one read. `done` rises on the following edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `sysid_pkg`:
  - the state enum;
  - default constants SYSID_ID_DEFAULT and SYSID_TIMESTAMP_DEFAULT, which are also used by the sysid generator script;
  - Avalon address constants ADDR_ID=0 and ADDR_TS=1.
- Single module. No sub-module is needed; the stall counter is inline.

## Test plan
1. Zero-wait slave returning 11 and 1447854940; `waitrequest`=0 → `done` in cycle 4, `pass`=1, `id_value`=11, `ts_value`=1447854940.
2. Slave returns ID 12 → `done`=1, `pass`=0, `timeout`=0, `id_value`=12.
3. Timestamp 1447854941 with CHECK_TIMESTAMP=0 → `pass`=1. Same stimulus with CHECK_TIMESTAMP=1 → `pass`=0.
4. `waitrequest` held for 3 cycles on each read, TIMEOUT_CYCLES=255 → `done` 6 cycles later than scenario 1, `pass`=1, `address` stable during the stalls.
5. `waitrequest` stuck at 1, TIMEOUT_CYCLES=4 → `read` drops and `timeout`=1, `pass`=0 after 4 stall cycles.
6. Reset asserted during RD_TS, then `start` pulsed with AUTO_START=0 → all outputs zero after reset; the check reruns and `pass`=1. A `start` pulsed while `busy` has no effect.
